// File: rtl/mod107_chunk_reducer.sv
// mod107_chunk_reducer
//
// Reduces a wide operand modulo MOD by walking it in CHUNK-bit slices,
// lowest slice first. Each slice is presented to an external, shared bank of
// chunk-residue LUTs (lut_idx selects the LUT, lut_x is the slice). The
// residue lut_z comes back combinationally in the same cycle and is folded
// into a running accumulator with a single conditional subtract.
//
// States
//   state  | meaning
//   IDLE   | waiting for an operand, in_ready=1
//   RUN    | one chunk per cycle, NCH cycles, busy=1
//   DONE   | result presented, out_valid=1 until out_ready
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake, in_data sampled only on accept
//   lut_idx, lut_x      LUT select and chunk (zero outside RUN)
//   lut_z               residue returned by the selected LUT
//   out_valid/out_ready result handshake, out_res = operand mod MOD
//   busy                high in RUN
//   err                 sticky: an out-of-range lut_z was seen this operation

module mod107_chunk_reducer #(
    parameter int N_BITS = 300,
    parameter int CHUNK  = 6,
    parameter int MOD    = 107,
    parameter int RW     = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] in_data,
    output logic [5:0]        lut_idx,
    output logic [CHUNK-1:0]  lut_x,
    input  logic [RW-1:0]     lut_z,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RW-1:0]     out_res,
    output logic              busy,
    output logic              err
);

    localparam int NCH = N_BITS / CHUNK;
    localparam logic [5:0] LAST_IDX = 6'(NCH - 1);
    localparam logic [RW:0] MOD_W = (RW + 1)'(MOD);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [N_BITS-1:0]   data_q, data_d;
    logic [5:0]          idx_q, idx_d;
    logic [RW-1:0]       acc_q, acc_d;
    logic [RW-1:0]       res_q, res_d;
    logic                err_q, err_d;

    logic                accept;
    logic                last_chunk;
    logic [RW:0]         sum;
    logic [RW-1:0]       acc_next;
    logic                z_bad;

    assign accept     = (state_q == S_IDLE) && in_valid;
    assign last_chunk = (idx_q == LAST_IDX);

    // acc < MOD and lut_z < 2^RW, so one extra bit holds the sum and a single
    // subtract brings a legal sum back into range. Illegal lut_z values go
    // through the same rule and give a deterministic (flagged) result.
    assign sum      = {1'b0, acc_q} + {1'b0, lut_z};
    assign acc_next = (sum >= MOD_W) ? RW'(sum - MOD_W) : sum[RW-1:0];
    assign z_bad    = ({1'b0, lut_z} >= MOD_W);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid)   state_d = S_RUN;
            S_RUN:  if (last_chunk) state_d = S_DONE;
            S_DONE: if (out_ready)  state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            idx_q  <= '0;
            acc_q  <= '0;
            res_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            idx_q  <= idx_d;
            acc_q  <= acc_d;
            res_q  <= res_d;
            err_q  <= err_d;
        end
    end

    // The operand is shifted down one chunk per RUN cycle so the current
    // chunk is always in the low bits; no wide variable-index mux is needed.
    always_comb begin
        data_d = data_q;
        idx_d  = idx_q;
        acc_d  = acc_q;
        res_d  = res_q;
        err_d  = err_q;
        if (accept) begin
            data_d = in_data;
            idx_d  = '0;
            acc_d  = '0;
            err_d  = 1'b0;
        end else if (state_q == S_RUN) begin
            data_d = data_q >> CHUNK;
            acc_d  = acc_next;
            err_d  = err_q | z_bad;
            if (last_chunk) begin
                res_d = acc_next;
            end else begin
                idx_d = idx_q + 6'd1;
            end
        end
    end

    // Outputs, decoded from registered state only
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q == S_RUN);
        out_valid = (state_q == S_DONE);
        out_res   = res_q;
        err       = err_q;
        lut_idx   = '0;
        lut_x     = '0;
        if (state_q == S_RUN) begin
            lut_idx = idx_q;
            lut_x   = data_q[CHUNK-1:0];
        end
    end

endmodule

// File: tb/tb_mod107_chunk_reducer.sv
module tb_mod107_chunk_reducer;

    localparam int N_BITS = 300;
    localparam int CHUNK  = 6;
    localparam int MOD    = 107;
    localparam int RW     = 7;
    localparam int NCH    = 50;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N_BITS-1:0] in_data = '0;
    logic [5:0]        lut_idx;
    logic [CHUNK-1:0]  lut_x;
    logic [RW-1:0]     lut_z;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [RW-1:0]     out_res;
    logic              busy;
    logic              err;

    int lut_mode = 0;   // 0: true chunk weight, 1: constant stub
    int stub_val = 0;
    int bad_idx  = -1;  // stub mode only: this index returns 120

    int n_pass  = 0;
    int n_total = 0;

    mod107_chunk_reducer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .lut_idx   (lut_idx),
        .lut_x     (lut_x),
        .lut_z     (lut_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // External LUT bank model
    always_comb begin
        int w;
        int z;
        w = 1;
        z = 0;
        for (int k = 0; k < NCH; k++) begin
            if (k < int'(lut_idx)) w = (w * 64) % MOD;
        end
        if (lut_mode == 0) z = (int'(lut_x) * w) % MOD;
        else               z = stub_val;
        if (lut_mode != 0 && int'(lut_idx) == bad_idx) z = 120;
        lut_z = RW'(z);
    end

    function automatic int ref_mod(input logic [N_BITS-1:0] v);
        int r;
        r = 0;
        for (int i = N_BITS - 1; i >= 0; i--) r = (r * 2 + int'(v[i])) % MOD;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Accept one operand and follow it to DONE. lat counts cycles from the
    // accept cycle to the first cycle with out_valid high.
    task automatic run_op(input logic [N_BITS-1:0] d, output int res, output int errv,
                          output int lat, output int steps, output int idx_bad,
                          output int first_err);
        int cnt;
        bit done;
        cnt = 0;
        while (!in_ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        in_data   = ~d;
        lat       = 1;
        steps     = 0;
        idx_bad   = 0;
        first_err = -1;
        done      = 1'b0;
        while (!done) begin
            if (busy) begin
                if (int'(lut_idx) != steps) idx_bad++;
                if (err && first_err < 0) first_err = int'(lut_idx);
                steps++;
            end
            if (out_valid || lat >= 200) done = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        res  = int'(out_res);
        errv = int'(err);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [N_BITS-1:0] data;
        int mode;
        int stub;
        int bad;
        int exp_res;
        int exp_err;
        int exp_first;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [N_BITS-1:0] top_bit;
        logic [319:0]      wide;
        int res, errv, lat, steps, idx_bad, first_err, cnt, hold_bad;

        top_bit = '0;
        top_bit[N_BITS-1] = 1'b1;

        vecs[0] = '{300'd0,   0, 0,   -1, 0,  0, -1};
        vecs[1] = '{300'd1,   0, 0,   -1, 1,  0, -1};
        vecs[2] = '{300'd107, 0, 0,   -1, 0,  0, -1};
        vecs[3] = '{300'd108, 0, 0,   -1, 1,  0, -1};
        vecs[4] = '{top_bit,  0, 0,   -1, 98, 0, -1};
        vecs[5] = '{300'hdead, 1, 1,  -1, 50, 0, -1};
        vecs[6] = '{300'hbeef, 1, 106, -1, 57, 0, -1};
        vecs[7] = '{300'h1234, 1, 1,   7, 62, 1, 8};

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready",  int'(in_ready),  1);
        check("rst_busy",      int'(busy),      0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_res",   int'(out_res),   0);
        check("rst_err",       int'(err),       0);
        check("rst_lut_idx",   int'(lut_idx),   0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven operations
        for (int v = 0; v < 8; v++) begin
            lut_mode = vecs[v].mode;
            stub_val = vecs[v].stub;
            bad_idx  = vecs[v].bad;
            run_op(vecs[v].data, res, errv, lat, steps, idx_bad, first_err);
            check($sformatf("v%0d_res", v),       res,       vecs[v].exp_res);
            check($sformatf("v%0d_err", v),       errv,      vecs[v].exp_err);
            check($sformatf("v%0d_latency", v),   lat,       51);
            check($sformatf("v%0d_steps", v),     steps,     NCH);
            check($sformatf("v%0d_idx_seq", v),   idx_bad,   0);
            check($sformatf("v%0d_first_err", v), first_err, vecs[v].exp_first);
            release_out();
            check($sformatf("v%0d_idle_ready", v), int'(in_ready),  1);
            check($sformatf("v%0d_idle_ovalid", v), int'(out_valid), 0);
            check($sformatf("v%0d_idle_lut", v),   int'(lut_idx) + int'(lut_x), 0);
            check($sformatf("v%0d_idle_res", v),   int'(out_res),   vecs[v].exp_res);
            check($sformatf("v%0d_idle_err", v),   int'(err),       vecs[v].exp_err);
        end

        // Backpressure in DONE, then release and immediate re-accept
        lut_mode = 0;
        bad_idx  = -1;
        run_op(300'd108, res, errv, lat, steps, idx_bad, first_err);
        check("bp_res", res, 1);
        check("bp_err_cleared", errv, 0);
        in_valid = 1'b1;
        in_data  = 300'd5;
        hold_bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!out_valid || out_res != 7'd1 || in_ready || busy) hold_bad++;
        end
        check("bp_hold", hold_bad, 0);
        out_ready = 1'b1;
        in_data   = 300'd108;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle_ready",  int'(in_ready),  1);
        check("bp_idle_ovalid", int'(out_valid), 0);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '1;
        check("bp_reaccept_busy", int'(busy),    1);
        check("bp_reaccept_idx",  int'(lut_idx), 0);
        cnt = 1;
        while (!out_valid && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("bp_second_latency", cnt, 51);
        check("bp_second_res", int'(out_res), 1);
        release_out();

        // Asynchronous reset in the middle of RUN
        lut_mode = 1;
        stub_val = 1;
        bad_idx  = 7;
        in_data  = 300'habcdef;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        while (lut_idx != 6'd20 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("mid_reached_idx20", int'(lut_idx), 20);
        check("mid_err_before",    int'(err),     1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy",      int'(busy),      0);
        check("mid_rst_in_ready",  int'(in_ready),  1);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_out_res",   int'(out_res),   0);
        check("mid_rst_err",       int'(err),       0);
        check("mid_rst_lut_idx",   int'(lut_idx),   0);
        check("mid_rst_lut_x",     int'(lut_x),     0);
        @(negedge clk);
        rst_n    = 1'b1;
        lut_mode = 0;
        bad_idx  = -1;
        @(negedge clk);
        run_op(top_bit, res, errv, lat, steps, idx_bad, first_err);
        check("post_rst_res",     res,     98);
        check("post_rst_latency", lat,     51);
        check("post_rst_idx_seq", idx_bad, 0);
        check("post_rst_steps",   steps,   NCH);
        release_out();

        // Random operands against a bitwise reference
        for (int r = 0; r < 1000; r++) begin
            for (int w = 0; w < 10; w++) wide[w*32 +: 32] = $urandom;
            run_op(wide[N_BITS-1:0], res, errv, lat, steps, idx_bad, first_err);
            check($sformatf("rand%0d_res", r), res, ref_mod(wide[N_BITS-1:0]));
            release_out();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
